// File: rtl/pg_seq_ctrl.sv
// pg_seq_ctrl: power-gating sequencer for a switch-level gated logic domain.
// Orders isolation clamps, retention save/restore strobes and the PMOS header
// gate. The gated cells must never drive undefined values into always-on logic.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_n_i     synchronous active-low reset (forces ACTIVE, domain powered)
//   pwr_req_i   level request: 1 = powered, 0 = gated
//   rail_ok_i   virtual-VDD good from the gated rail
//   pwr_ack_o   level acknowledge, follows pwr_req_i once a sequence completes
//   hdr_gate_o  PMOS header gate: 0 = header on, 1 = header off
//   iso_en_o    isolation clamp enable
//   save_o      one-cycle retention save strobe
//   restore_o   one-cycle retention restore strobe
//   busy_o      high while a sleep/wake sequence is in flight
module pg_seq_ctrl #(
    parameter int ISO_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int WAKE_CYCLES  = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pwr_req_i,
    input  logic rail_ok_i,
    output logic pwr_ack_o,
    output logic hdr_gate_o,
    output logic iso_en_o,
    output logic save_o,
    output logic restore_o,
    output logic busy_o
);

    localparam int MAX_ID = (ISO_CYCLES > DRAIN_CYCLES) ? ISO_CYCLES : DRAIN_CYCLES;
    localparam int MAX_C  = (MAX_ID > WAKE_CYCLES) ? MAX_ID : WAKE_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;

    // Counter load values: a state lasting N cycles loads N-1 and leaves at 0.
    localparam logic [CW-1:0] ISO_LD   = CW'(ISO_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LD  = CW'(WAKE_CYCLES - 1);

    localparam logic [2:0] S_ACTIVE     = 3'd0;
    localparam logic [2:0] S_ISOLATE    = 3'd1;
    localparam logic [2:0] S_SAVE       = 3'd2;
    localparam logic [2:0] S_POWER_DOWN = 3'd3;
    localparam logic [2:0] S_OFF        = 3'd4;
    localparam logic [2:0] S_POWER_UP   = 3'd5;
    localparam logic [2:0] S_RESTORE    = 3'd6;
    localparam logic [2:0] S_DEISOLATE  = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hdr_q, hdr_d;
    logic          iso_q, iso_d;
    logic          save_q, save_d;
    logic          rest_q, rest_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;

    logic cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    // Next state. pwr_req_i is only looked at in ACTIVE and OFF, so a request
    // that toggles mid-sequence is never acted on until the sequence finishes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_ACTIVE: begin
                if (!pwr_req_i) begin
                    state_d = S_ISOLATE;
                    cnt_d   = ISO_LD;
                end
            end
            S_ISOLATE: begin
                if (cnt_zero) state_d = S_SAVE;
                else          cnt_d   = cnt_q - 1'b1;
            end
            S_SAVE: begin
                state_d = S_POWER_DOWN;
                cnt_d   = DRAIN_LD;
            end
            S_POWER_DOWN: begin
                if (cnt_zero) state_d = S_OFF;
                else          cnt_d   = cnt_q - 1'b1;
            end
            S_OFF: begin
                if (pwr_req_i) begin
                    state_d = S_POWER_UP;
                    cnt_d   = WAKE_LD;
                end
            end
            S_POWER_UP: begin
                // rail_ok_i is untrusted until the minimum wake time elapses;
                // after that, wait on it indefinitely.
                if (!cnt_zero)      cnt_d   = cnt_q - 1'b1;
                else if (rail_ok_i) state_d = S_RESTORE;
            end
            S_RESTORE: begin
                state_d = S_DEISOLATE;
                cnt_d   = ISO_LD;
            end
            S_DEISOLATE: begin
                if (cnt_zero) state_d = S_ACTIVE;
                else          cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = S_ACTIVE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and are glitch-free.
    always_comb begin
        hdr_d  = 1'b0;
        iso_d  = 1'b1;
        save_d = 1'b0;
        rest_d = 1'b0;
        ack_d  = 1'b0;
        busy_d = 1'b1;
        case (state_d)
            S_ISOLATE:    ack_d = 1'b1;
            S_SAVE:       begin save_d = 1'b1; ack_d = 1'b1; end
            S_POWER_DOWN: begin hdr_d = 1'b1; ack_d = 1'b1; end
            S_OFF:        begin hdr_d = 1'b1; busy_d = 1'b0; end
            S_POWER_UP:   begin end
            S_RESTORE:    rest_d = 1'b1;
            S_DEISOLATE:  begin end
            default:      begin iso_d = 1'b0; ack_d = 1'b1; busy_d = 1'b0; end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_ACTIVE;
            cnt_q   <= '0;
            hdr_q   <= 1'b0;
            iso_q   <= 1'b0;
            save_q  <= 1'b0;
            rest_q  <= 1'b0;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            iso_q   <= iso_d;
            save_q  <= save_d;
            rest_q  <= rest_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign hdr_gate_o = hdr_q;
    assign iso_en_o   = iso_q;
    assign save_o     = save_q;
    assign restore_o  = rest_q;
    assign pwr_ack_o  = ack_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_pg_seq_ctrl.sv
// Self-checking bench for pg_seq_ctrl: a vector table for the default sleep
// and wake sequences, hand-written corner sequences, and random stimulus
// compared against a timeline model of the sequencer.
module tb_pg_seq_ctrl;

    localparam int ISO   = 2;
    localparam int DRAIN = 4;
    localparam int WAKE  = 8;

    logic clk = 1'b0;
    logic rst_n, pwr_req, rail_ok;
    logic pwr_ack, hdr_gate, iso_en, save, restore, busy;

    always #5 clk = ~clk;

    pg_seq_ctrl #(.ISO_CYCLES(ISO), .DRAIN_CYCLES(DRAIN), .WAKE_CYCLES(WAKE)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .pwr_req_i  (pwr_req),
        .rail_ok_i  (rail_ok),
        .pwr_ack_o  (pwr_ack),
        .hdr_gate_o (hdr_gate),
        .iso_en_o   (iso_en),
        .save_o     (save),
        .restore_o  (restore),
        .busy_o     (busy)
    );

    // Observation vector: {hdr_gate, iso_en, save, restore, pwr_ack, busy}
    logic [5:0] obs;
    assign obs = {hdr_gate, iso_en, save, restore, pwr_ack, busy};

    int errors = 0;
    int checks = 0;

    // Timeline model: idle powered, idle gated, or N edges into a sequence.
    localparam int M_ON = 0, M_OFF = 1, M_SLEEP = 2, M_WAKE = 3;
    int m_mode = M_ON;
    int m_e    = 0;    // edges elapsed since the sequence's start edge
    int m_r    = -1;   // edge (relative) at which rail_ok was accepted

    task automatic model_edge(input logic rst, input logic req, input logic rail);
        if (!rst) begin
            m_mode = M_ON;
        end else begin
            case (m_mode)
                M_ON:  if (!req) begin m_mode = M_SLEEP; m_e = 0; end
                M_OFF: if (req) begin m_mode = M_WAKE; m_e = 0; m_r = -1; end
                M_SLEEP: begin
                    m_e++;
                    if (m_e == ISO + DRAIN + 1) m_mode = M_OFF;
                end
                default: begin
                    m_e++;
                    if (m_r < 0 && m_e >= WAKE && rail) m_r = m_e;
                    else if (m_r >= 0 && m_e == m_r + 1 + ISO) m_mode = M_ON;
                end
            endcase
        end
    endtask

    function automatic logic [5:0] model_out();
        logic [5:0] v;
        case (m_mode)
            M_ON:    v = 6'b000010;
            M_OFF:   v = 6'b110000;
            M_SLEEP: v = {(m_e > ISO), 1'b1, (m_e == ISO), 1'b0, 1'b1, 1'b1};
            default: v = {1'b0, 1'b1, 1'b0, (m_r >= 0 && m_e == m_r), 1'b0, 1'b1};
        endcase
        return v;
    endfunction

    task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample at the falling edge, and
    // compare against the model plus the structural invariants.
    task automatic step(input logic rst, input logic req, input logic rail, input string name);
        rst_n   = rst;
        pwr_req = req;
        rail_ok = rail;
        @(posedge clk);
        model_edge(rst, req, rail);
        @(negedge clk);
        check6({name, " model"}, obs, model_out());
        check1({name, " iso_when_hdr"}, hdr_gate & ~iso_en, 1'b0);
        check1({name, " save_restore_excl"}, save & restore, 1'b0);
        check1({name, " strobe_hdr_on"}, (save | restore) & hdr_gate, 1'b0);
    endtask

    typedef struct packed {
        logic       rst;
        logic       req;
        logic       rail;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // reset, then default sleep (edges 0..7), then default wake (edges 0..11)
        tbl[0] = '{1'b0, 1'b1, 1'b0, 6'b000010};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 6'b010011};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 6'b010011};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 6'b011011};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 6'b110011};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 6'b110011};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 6'b110011};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 6'b110011};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 6'b110000};
        for (int i = 9; i <= 16; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 6'b010001};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 6'b010101};
        tbl[18] = '{1'b1, 1'b1, 1'b1, 6'b010001};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 6'b010001};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 6'b000010};

        rst_n = 1'b0; pwr_req = 1'b1; rail_ok = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rail, $sformatf("tbl[%0d]", i));
            check6($sformatf("tbl[%0d] vec", i), obs, tbl[i].exp);
        end

        // Idle with request held: nothing moves.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, $sformatf("idle[%0d]", i));
            check1($sformatf("idle[%0d] busy", i), busy, 1'b0);
        end

        // Sleep to OFF, then wake with rail_ok low until edge 15.
        for (int e = 0; e < 8; e++) step(1'b1, 1'b0, 1'b0, $sformatf("slp2[%0d]", e));
        check1("slp2 off ack", pwr_ack, 1'b0);
        for (int e = 0; e <= 18; e++) begin
            step(1'b1, 1'b1, (e >= 15), $sformatf("railw[%0d]", e));
            if (e == 14) check1("railw restore early", restore, 1'b0);
            if (e == 15) check1("railw restore", restore, 1'b1);
            if (e == 17) check1("railw ack early", pwr_ack, 1'b0);
            if (e == 18) check1("railw ack", pwr_ack, 1'b1);
        end

        // Drop request, re-raise at edge 2: sleep completes, then wake.
        for (int e = 0; e <= 19; e++) begin
            step(1'b1, (e >= 2), 1'b1, $sformatf("tog[%0d]", e));
            if (e == 7) check6("tog off", obs, 6'b110000);
            if (e == 8) check1("tog wake hdr", hdr_gate, 1'b0);
            if (e == 18) check1("tog ack early", pwr_ack, 1'b0);
            if (e == 19) check6("tog active", obs, 6'b000010);
        end

        // Reset at edge 5 of a sleep sequence; no restore afterwards.
        for (int e = 0; e <= 14; e++) begin
            step((e != 5), (e >= 5), 1'b1, $sformatf("rstmid[%0d]", e));
            if (e == 4) check1("rstmid hdr before", hdr_gate, 1'b1);
            if (e == 5) check6("rstmid after", obs, 6'b000010);
            if (e > 5)  check1($sformatf("rstmid[%0d] no restore", e), restore, 1'b0);
        end

        // Random stimulus against the model.
        begin
            logic req_r;
            req_r = 1'b1;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 9) == 0) req_r = ~req_r;
                step(($urandom_range(0, 99) != 0), req_r, $urandom_range(0, 1) == 1,
                     $sformatf("rnd[%0d]", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pg_seq_ctrl.md
# pg_seq_ctrl

Synchronous power-gating sequencer for a switch-level CMOS logic domain (NAND/NOR cell clusters built from pmos/nmos primitives). It drives the gate of the domain's PMOS header switch, the output isolation clamps and the state-retention save/restore strobes. It orders them so the gated cells never drive undefined values into always-on logic. It sits in the always-on domain, between a power-management requester (level handshake) and the gated block.

## Interface
- ISO_CYCLES, 2: cycles isolation is held before power-down and after power-up (≥1).
- DRAIN_CYCLES, 4: cycles the header is held off before the domain is declared OFF (≥1).
- WAKE_CYCLES, 8: minimum cycles after the header is turned on before `rail_ok` is honoured (≥1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- pwr_req  input  1  level request: 1 = domain powered, 0 = domain gated.
- rail_ok  input  1  virtual-VDD good indication from the gated rail.
- pwr_ack  output  1  level acknowledge; equals `pwr_req` once the sequence completes.
- hdr_gate  output  1  PMOS header gate: 0 = header on (domain powered), 1 = header off.
- iso_en  output  1  isolation clamp enable, active high.
- save  output  1  one-cycle retention save strobe.
- restore  output  1  one-cycle retention restore strobe.
- busy  output  1  high in every state except ACTIVE and OFF.

## Operation
- Moore FSM; all outputs are registered and decoded from state. One down-counter is shared by the ISOLATE, POWER_DOWN, POWER_UP and DEISOLATE states.
- Counter width is $clog2(max(ISO_CYCLES, DRAIN_CYCLES, WAKE_CYCLES))+1. The counter loads the state's parameter minus 1 on state entry and decrements to 0.
- ACTIVE: hdr_gate=0, iso_en=0, pwr_ack=1. `pwr_req`=0 → ISOLATE.
- ISOLATE: iso_en=1. Stays ISO_CYCLES cycles → SAVE.
- SAVE: iso_en=1, save=1 for exactly one cycle → POWER_DOWN.
- POWER_DOWN: iso_en=1, hdr_gate=1. Stays DRAIN_CYCLES cycles → OFF.
- OFF: iso_en=1, hdr_gate=1, pwr_ack=0. `pwr_req`=1 → POWER_UP.
- POWER_UP: iso_en=1, hdr_gate=0. After WAKE_CYCLES cycles, waits with no timeout until `rail_ok`=1 → RESTORE. `rail_ok` is ignored while the counter is nonzero.
- RESTORE: iso_en=1, restore=1 for exactly one cycle → DEISOLATE.
- DEISOLATE: iso_en=1, hdr_gate=0. Stays ISO_CYCLES cycles → ACTIVE.
- No abort: `pwr_req` changes during a busy state are ignored. They are acted on only when the FSM reaches ACTIVE or OFF, and only by the level sampled there. A request that toggles and returns before completion therefore produces no second sequence.
- Invariants:
  - iso_en=1 whenever hdr_gate=1.
  - `save` and `restore` are never high together.
  - `save` is asserted only while hdr_gate=0; `restore` is asserted only while hdr_gate=0 and after rail_ok has been seen.

## Timing
- Reset (rst_n=0 at a rising edge): state ACTIVE, counter 0. Outputs: hdr_gate=0, iso_en=0, save=0, restore=0, pwr_ack=1, busy=0.
- Reset mid-sequence (including OFF) forces ACTIVE on that edge, so the domain is re-powered immediately. No restore strobe is issued.
- Sleep, numbered from edge 0 where pwr_req=0 is sampled in ACTIVE:
  - iso_en and busy rise after edge 0.
  - save is high between edges ISO_CYCLES and ISO_CYCLES+1.
  - hdr_gate rises after edge ISO_CYCLES+1.
  - pwr_ack falls and busy falls after edge ISO_CYCLES+DRAIN_CYCLES+1 (defaults: edge 7).
- Wake, numbered from edge 0 where pwr_req=1 is sampled in OFF:
  - hdr_gate falls after edge 0.
  - The earliest transition to RESTORE is edge WAKE_CYCLES, if rail_ok=1 there.
  - restore is high for one cycle.
  - iso_en falls, pwr_ack rises and busy falls after edge WAKE_CYCLES+1+ISO_CYCLES (defaults: edge 11).
- Each cycle rail_ok is low at or after edge WAKE_CYCLES extends the wake latency by exactly one cycle.

## Test plan
- Reset, then hold pwr_req=1 for 20 cycles → outputs stay at reset values, busy=0 throughout.
- Defaults, drop pwr_req at edge 0 → iso_en=1 after edge 0, save pulse during cycle 2→3, hdr_gate=1 after edge 3, pwr_ack=0 after edge 7. Check iso_en=1 whenever hdr_gate=1.
- From OFF, raise pwr_req with rail_ok=1 → hdr_gate=0 after edge 0, restore pulse during cycle 8→9, iso_en=0 and pwr_ack=1 after edge 11.
- From OFF, raise pwr_req with rail_ok held low until edge 15 → FSM stays in POWER_UP, restore pulse during cycle 15→16, pwr_ack=1 after edge 18.
- Drop pwr_req, re-raise it at edge 2 → sleep runs to completion (pwr_ack=0 after edge 7), then a wake sequence starts at edge 8 and pwr_ack=1 after edge 19.
- Assert rst_n=0 at edge 5 of a sleep sequence → after that edge hdr_gate=0, iso_en=0, save=0, pwr_ack=1, busy=0. No restore pulse is emitted.
